ic_gate_test_sequencer: RTL and testbench
=========================================

# ic_gate_test_sequencer

Sequencer that drives the per-gate test of a multi-gate 2-input logic IC (default six gates). It walks every gate through all four input vectors, waits for the device output to settle, and compares it against the expected truth table. It then produces per-gate pass/fail flags and running tallies. Its pass/fail vectors feed the tester's pass/fail counting and display path, and it sits between the start/IC-present controls and the DUT pin drivers.

## Interface
- `NUM_GATES`, default 6: number of gates on the IC under test.
- `SETTLE_CYCLES`, default 4, minimum 1: cycles each vector is held before sampling.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level-sampled; begins a test run when accepted in IDLE.
- `icg`, input, 1: IC present/good-contact; a run is allowed only while it is 1.
- `truth`, input, 4: expected output per vector, indexed as `truth[{a,b}]`; must stay stable during a run.
- `gate_out`, input, NUM_GATES: DUT gate outputs, already synchronised.
- `gate_sel`, output, NUM_GATES: one-hot select of the gate currently driven; all 0 when not testing.
- `drv_a`, `drv_b`, output, 1 each: vector applied to the selected gate.
- `pass`, output, NUM_GATES: bit i set when gate i completes with all 4 vectors matching.
- `fail`, output, NUM_GATES: bit i set when gate i completes with at least one mismatch.
- `pass_cnt`, `fail_cnt`, output, 4 each: popcount of `pass` / `fail`.
- `busy`, output, 1: high in all states except IDLE.
- `done`, output, 1: one-cycle pulse when a run completes normally.
- `aborted`, output, 1: one-cycle pulse when a run is cut short by `icg` falling.

## Operation
- States: IDLE, DRIVE, SAMPLE, FINISH.
- **IDLE**
  - Outputs are quiet: `gate_sel`=0, `drv_a`=`drv_b`=0.
  - `start`=1 and `icg`=1 → clear `pass`, `fail` and both counts; set gate=0, vec=0, settle counter=0; go to DRIVE.
  - `start` with `icg`=0 is ignored.
- **DRIVE**
  - `gate_sel` = one-hot(gate); `{drv_a,drv_b}` = vec.
  - Vector order is 00, 01, 10, 11.
  - Settle counter increments; after SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- **SAMPLE**
  - Outputs are still driven with the same vector.
  - Compare `gate_out[gate]` with `truth[vec]`; OR any mismatch into a per-gate mismatch flag.
  - vec<3 → vec+1, go to DRIVE.
  - vec=3 → set `pass[gate]` (no mismatch, counting this sample) or `fail[gate]`, increment the matching count, then clear the mismatch flag.
  - If gate<NUM_GATES-1: gate+1, vec=0, go to DRIVE. Otherwise go to FINISH.
- **FINISH**
  - `done`=1 for this cycle; `gate_sel`=0.
  - Go to IDLE.
- **Results hold:** `pass`, `fail` and the counts hold their values in IDLE until the next accepted `start`.
- **Abort:** `icg`=0 in any of DRIVE, SAMPLE or FINISH → next state IDLE with `aborted`=1 for one cycle.
  - `pass`, `fail` and the counts are cleared.
  - No `done` pulse.
  - Abort has priority over a FINISH transition on the same edge.
- **Start while busy:** `start` while busy is ignored; there is no queuing.
- **Invariants:**
  - `pass[i]` and `fail[i]` are never both 1.
  - Gates not yet tested read 0 in both vectors.
  - Counts never exceed NUM_GATES, so 4 bits suffice for NUM_GATES ≤ 15.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE, asynchronously on `rst_n`=0. Reset mid-run discards the run with no `done` and no `aborted` pulse.
- **Start latency:** `start` sampled at edge k → `busy`=1 and the first vector driven from edge k+1.
- **Per vector:** SETTLE_CYCLES DRIVE cycles + 1 SAMPLE cycle.
- **Per gate:** 4·(SETTLE_CYCLES+1) cycles.
- **Run length:** `done` is asserted in cycle NUM_GATES·4·(SETTLE_CYCLES+1)+1 after the start edge. With defaults: 6·4·5+1 = 121.
- **Result update:** `pass[i]`/`fail[i]` and the count update on the edge that leaves gate i's final SAMPLE, so they are visible in the next cycle.
- **Back-to-back runs:** `start` held high re-triggers in the IDLE cycle following FINISH. Minimum gap between runs is 1 IDLE cycle.
- **Abort response:** `icg` is sampled synchronously; `gate_sel` is 0 from the edge after `icg` is seen low.

## Test plan
- **Good NAND:** `truth`=4'b0111, DUT model NAND on all gates, defaults → `pass`=6'h3F, `fail`=0, `pass_cnt`=6, `done` pulse 121 cycles after start, `busy` low the cycle after.
- **One faulty gate:** gate 2 stuck-at-0 → `pass`=6'h3B, `fail`=6'h04, `pass_cnt`=5, `fail_cnt`=1.
- **Abort:** `icg` dropped during gate 3, vector 01 → `aborted` pulse, `pass`=`fail`=0, no `done`, `gate_sel`=0 the next cycle.
- **Start gating:** `start` with `icg`=0 → stays IDLE. `start` re-pulsed mid-run → no restart and results unchanged.
- **Reset mid-run:** `rst_n` low at cycle 50 → all outputs 0 immediately; a fresh start afterwards completes normally.
- **Minimum settle:** SETTLE_CYCLES=1, gate 5 output inverted → `fail`=6'h20, `done` at 6·4·2+1 = 49 cycles, `drv_a`/`drv_b` sequence 00,01,10,11 per gate.

Source files
------------

// File: rtl/ic_gate_test_sequencer.sv
// Per-gate functional test sequencer for a multi-gate 2-input logic IC.
// Each gate gets vectors 00,01,10,11 applied, held for SETTLE_CYCLES, then sampled.
module ic_gate_test_sequencer #(
    parameter int unsigned NUM_GATES     = 6,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 icg,
    input  logic [3:0]           truth,
    input  logic [NUM_GATES-1:0] gate_out,
    output logic [NUM_GATES-1:0] gate_sel,
    output logic                 drv_a,
    output logic                 drv_b,
    output logic [NUM_GATES-1:0] pass,
    output logic [NUM_GATES-1:0] fail,
    output logic [3:0]           pass_cnt,
    output logic [3:0]           fail_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam int unsigned GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [GW-1:0] LastGate   = GW'(NUM_GATES - 1);
    localparam logic [SW-1:0] LastSettle = SW'(SETTLE_CYCLES - 1);
    localparam logic [NUM_GATES-1:0] GateOne = NUM_GATES'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        gate_q, gate_d;
    logic [1:0]           vec_q, vec_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 mism_q, mism_d;
    logic [NUM_GATES-1:0] pass_q, pass_d;
    logic [NUM_GATES-1:0] fail_q, fail_d;
    logic [3:0]           pass_cnt_q, pass_cnt_d;
    logic [3:0]           fail_cnt_q, fail_cnt_d;
    logic                 aborted_q, aborted_d;
    logic                 sample_miss;
    logic                 gate_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gate_q     <= '0;
            vec_q      <= '0;
            settle_q   <= '0;
            mism_q     <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            mism_q     <= mism_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        mism_d     = mism_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        aborted_d  = 1'b0;

        sample_miss = gate_out[gate_q] != truth[vec_q];
        gate_miss   = mism_q | sample_miss;

        unique case (state_q)
            StIdle: begin
                if (start && icg) begin
                    pass_d     = '0;
                    fail_d     = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    gate_d     = '0;
                    vec_d      = '0;
                    settle_d   = '0;
                    mism_d     = 1'b0;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (settle_q == LastSettle) begin
                    settle_d = '0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StSample: begin
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    mism_d  = gate_miss;
                    state_d = StDrive;
                end else begin
                    // Final vector of this gate: the current sample counts toward the verdict.
                    if (gate_miss) begin
                        fail_d[gate_q] = 1'b1;
                        fail_cnt_d     = fail_cnt_q + 4'd1;
                    end else begin
                        pass_d[gate_q] = 1'b1;
                        pass_cnt_d     = pass_cnt_q + 4'd1;
                    end
                    mism_d = 1'b0;
                    if (gate_q != LastGate) begin
                        gate_d  = gate_q + GW'(1);
                        vec_d   = '0;
                        state_d = StDrive;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Losing the IC overrides everything, including the FINISH->IDLE step.
        if (state_q != StIdle && !icg) begin
            state_d    = StIdle;
            aborted_d  = 1'b1;
            pass_d     = '0;
            fail_d     = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            mism_d     = 1'b0;
            settle_d   = '0;
        end
    end

    always_comb begin
        gate_sel = '0;
        drv_a    = 1'b0;
        drv_b    = 1'b0;
        if (state_q == StDrive || state_q == StSample) begin
            gate_sel = GateOne << gate_q;
            drv_a    = vec_q[1];
            drv_b    = vec_q[0];
        end
        busy     = state_q != StIdle;
        done     = (state_q == StFinish) && icg;
        aborted  = aborted_q;
        pass     = pass_q;
        fail     = fail_q;
        pass_cnt = pass_cnt_q;
        fail_cnt = fail_cnt_q;
    end

endmodule

// File: tb/tb_ic_gate_test_sequencer.sv
// Self-checking bench: two sequencers (settle 4 and settle 1) driven against a
// behavioural IC model whose gates each implement a 4-entry lookup table.
module tb_ic_gate_test_sequencer;

    localparam int NG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start    [2];
    logic          icg      [2];
    logic [3:0]    truth    [2];
    logic [NG-1:0] gate_out [2];
    logic [NG-1:0] gate_sel [2];
    logic          drv_a    [2];
    logic          drv_b    [2];
    logic [NG-1:0] pass     [2];
    logic [NG-1:0] fail     [2];
    logic [3:0]    pass_cnt [2];
    logic [3:0]    fail_cnt [2];
    logic          busy     [2];
    logic          done     [2];
    logic          aborted  [2];
    logic [3:0]    behav    [2][NG];

    int checks = 0;
    int errors = 0;

    ic_gate_test_sequencer #(.NUM_GATES(NG), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .icg(icg[0]), .truth(truth[0]),
        .gate_out(gate_out[0]), .gate_sel(gate_sel[0]), .drv_a(drv_a[0]), .drv_b(drv_b[0]),
        .pass(pass[0]), .fail(fail[0]), .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0])
    );

    ic_gate_test_sequencer #(.NUM_GATES(NG), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .icg(icg[1]), .truth(truth[1]),
        .gate_out(gate_out[1]), .gate_sel(gate_sel[1]), .drv_a(drv_a[1]), .drv_b(drv_b[1]),
        .pass(pass[1]), .fail(fail[1]), .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1])
    );

    // Unselected gates answer with the wrong value so a mis-indexed sample is caught.
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            gate_out[u] = '0;
            for (int i = 0; i < NG; i++) begin
                gate_out[u][i] = gate_sel[u][i] ? behav[u][i][{drv_a[u], drv_b[u]}]
                                                : ~truth[u][{drv_a[u], drv_b[u]}];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] snap(input int u);
        return {33'b0, gate_sel[u], drv_a[u], drv_b[u], busy[u], done[u], aborted[u],
                pass[u], fail[u], pass_cnt[u], fail_cnt[u]};
    endfunction

    function automatic logic [63:0] mk(input logic [NG-1:0] gs, input logic [1:0] vec,
                                       input logic b, input logic d, input logic a,
                                       input logic [NG-1:0] p, input logic [NG-1:0] f);
        return {33'b0, gs, vec, b, d, a, p, f, 4'($countones(p)), 4'($countones(f))};
    endfunction

    // A gate passes exactly when its lookup table equals the expected truth table.
    function automatic logic [NG-1:0] golden(input int u);
        logic [NG-1:0] r;
        for (int i = 0; i < NG; i++) r[i] = (behav[u][i] == truth[u]);
        return r;
    endfunction

    task automatic set_all(input int u, input logic [3:0] tt);
        truth[u] = tt;
        for (int i = 0; i < NG; i++) behav[u][i] = tt;
    endtask

    task automatic randomize_case(input int u);
        truth[u] = 4'($urandom);
        for (int i = 0; i < NG; i++)
            behav[u][i] = ($urandom_range(0, 1) == 1) ? truth[u] : 4'($urandom);
    endtask

    // Entered in cycle 1 of a run; leaves in the IDLE cycle after FINISH.
    task automatic track(input int u, input int s, input bit hold, input int pulse_at);
        int per_vec;
        int per_gate;
        int len;
        logic [NG-1:0] gp;
        logic [NG-1:0] mask;
        per_vec  = s + 1;
        per_gate = 4 * per_vec;
        len      = NG * per_gate;
        gp       = golden(u);
        for (int c = 1; c <= len; c++) begin
            int g;
            int v;
            g    = (c - 1) / per_gate;
            v    = ((c - 1) / per_vec) % 4;
            mask = (NG'(1) << g) - NG'(1);
            chk($sformatf("u%0d run cycle %0d", u, c), snap(u),
                mk(NG'(1) << g, 2'(v), 1'b1, 1'b0, 1'b0, gp & mask, ~gp & mask));
            if (c == pulse_at) start[u] = 1'b1;
            else if (!hold) start[u] = 1'b0;
            step();
        end
        chk($sformatf("u%0d done cycle %0d", u, len + 1), snap(u),
            mk('0, 2'b00, 1'b1, 1'b1, 1'b0, gp, ~gp));
        step();
        chk($sformatf("u%0d idle after done", u), snap(u),
            mk('0, 2'b00, 1'b0, 1'b0, 1'b0, gp, ~gp));
    endtask

    task automatic run(input int u, input int s, input int pulse_at);
        start[u] = 1'b1;
        step();
        track(u, s, 1'b0, pulse_at);
    endtask

    task automatic abort_run(input int u, input int s, input int ac);
        int per_vec;
        int len;
        per_vec = s + 1;
        len     = NG * 4 * per_vec;
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
        for (int c = 1; c < ac; c++) step();
        if (ac <= len)
            chk($sformatf("u%0d pre-abort vector @%0d", u, ac), 64'({gate_sel[u], drv_a[u], drv_b[u]}),
                64'({NG'(1) << ((ac - 1) / (4 * per_vec)), 2'(((ac - 1) / per_vec) % 4)}));
        icg[u] = 1'b0;
        #1;
        chk($sformatf("u%0d busy/done with icg low @%0d", u, ac), 64'({busy[u], done[u]}), 64'(2'b10));
        step();
        chk($sformatf("u%0d abort pulse", u), snap(u), mk('0, 2'b00, 1'b0, 1'b0, 1'b1, '0, '0));
        icg[u] = 1'b1;
        step();
        chk($sformatf("u%0d abort pulse ends", u), snap(u), mk('0, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            icg[u]   = 1'b1;
            set_all(u, 4'b0111);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset u0", snap(0), 64'd0);
        chk("reset u1", snap(1), 64'd0);
        rst_n = 1'b1;
        step();

        // Good NAND on every gate
        set_all(0, 4'b0111);
        run(0, 4, 0);
        chk("nand pass", 64'(pass[0]), 64'(6'h3F));
        chk("nand pass_cnt", 64'(pass_cnt[0]), 64'd6);

        // Gate 2 stuck at 0
        behav[0][2] = 4'b0000;
        run(0, 4, 0);
        chk("stuck pass", 64'(pass[0]), 64'(6'h3B));
        chk("stuck fail", 64'(fail[0]), 64'(6'h04));
        chk("stuck counts", 64'({pass_cnt[0], fail_cnt[0]}), 64'(8'h51));

        // Start with icg low is ignored; previous results hold
        icg[0]   = 1'b0;
        start[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("gated start %0d", k), snap(0),
                mk('0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h3B, 6'h04));
        end
        start[0] = 1'b0;
        icg[0]   = 1'b1;
        step();

        // Start re-pulsed mid-run is ignored
        randomize_case(0);
        run(0, 4, 30);

        // Abort during gate 3, vector 01
        set_all(0, 4'b0111);
        abort_run(0, 4, 66);
        // Abort at a random point, FINISH cycle included
        randomize_case(0);
        abort_run(0, 4, $urandom_range(1, 121));
        abort_run(0, 4, 121);

        // Reset mid-run at cycle 50
        randomize_case(0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (49) step();
        rst_n = 1'b0;
        #1;
        chk("mid-run reset u0", snap(0), 64'd0);
        chk("mid-run reset u1", snap(1), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        run(0, 4, 0);

        // Minimum settle, gate 5 inverted
        set_all(1, 4'b0111);
        behav[1][5] = 4'b1000;
        run(1, 1, 0);
        chk("min settle fail", 64'(fail[1]), 64'(6'h20));
        chk("min settle pass_cnt", 64'(pass_cnt[1]), 64'd5);

        // Back-to-back runs with start held high
        randomize_case(1);
        start[1] = 1'b1;
        step();
        track(1, 1, 1'b1, 0);
        step();
        track(1, 1, 1'b0, 0);

        // Random runs on both instances
        for (int k = 0; k < 3; k++) begin
            randomize_case(0);
            run(0, 4, 0);
            randomize_case(1);
            run(1, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
